// File: rtl/mssd_pkg.sv
`default_nettype none
// ============================================================================
// mssd_pkg : shared field widths, line levels and FSM encoding for the MSSD link
// Rev 1.0
// ============================================================================
package mssd_pkg;

  localparam int PORT_W   = 2;
  localparam int CNT_W    = 4;
  localparam int DATA_MAX = 15;

  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    START = 3'd2,
    PORT  = 3'd3,
    CNT   = 3'd4,
    DATA  = 3'd5,
    STOP  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tx_field_shifter.sv
`default_nettype none
// ============================================================================
// tx_field_shifter : parallel-load field shifter with bit index, steps on shift
// Rev 1.0
// ============================================================================
module tx_field_shifter
  import mssd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_shift,
  input  logic [DATA_MAX-1:0] i_val,
  input  logic [CNT_W-1:0]    i_last_idx,
  output logic                o_first,
  output logic                o_next,
  output logic                o_last
);

  // Bit 0 goes onto the line on the load edge, so only the rest is stored.
  logic [DATA_MAX-2:0] r_sh;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_last_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh       <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
    end else if (i_load) begin
      r_sh       <= i_val[DATA_MAX-1:1];
      r_idx      <= '0;
      r_last_idx <= i_last_idx;
    end else if (i_shift) begin
      r_sh       <= r_sh >> 1;
      r_idx      <= r_idx + CNT_W'(1);
    end
  end

  assign o_first = i_val[0];
  assign o_next  = r_sh[0];
  assign o_last  = (r_idx == r_last_idx);

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// serial_frame_tx : MSSD frame transmitter (start, port, count, payload), clk_en paced
// Rev 1.0
// ============================================================================
module serial_frame_tx
  import mssd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                start,
  input  logic [PORT_W-1:0]   port_num,
  input  logic [CNT_W-1:0]    data_num,
  input  logic [DATA_MAX-1:0] data,
  output logic                SerOut,
  output logic                busy,
  output logic                done,
  output logic [CNT_W:0]      remain
);

  state_t              r_state;
  logic [PORT_W-1:0]   r_port;
  logic [CNT_W-1:0]    r_n;
  logic [DATA_MAX-1:0] r_data;

  logic [PORT_W-1:0]   w_port_rev;
  logic [CNT_W-1:0]    w_cnt_rev;
  logic                w_load;
  logic                w_shift;
  logic [DATA_MAX-1:0] w_val;
  logic [CNT_W-1:0]    w_last_idx;
  logic                w_first;
  logic                w_next;
  logic                w_last;

  // Header fields go out MSB first; reversing lets one LSB-first shifter serve all fields.
  always_comb begin
    w_port_rev = '0;
    w_cnt_rev  = '0;
    for (int i = 0; i < PORT_W; i++) w_port_rev[i] = r_port[PORT_W-1-i];
    for (int i = 0; i < CNT_W; i++)  w_cnt_rev[i]  = r_n[CNT_W-1-i];
  end

  always_comb begin
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_val      = '0;
    w_last_idx = '0;
    if (clk_en) begin
      case (r_state)
        START: begin
          w_load     = 1'b1;
          w_val      = DATA_MAX'(w_port_rev);
          w_last_idx = CNT_W'(PORT_W - 1);
        end
        PORT: begin
          if (w_last) begin
            w_load     = 1'b1;
            w_val      = DATA_MAX'(w_cnt_rev);
            w_last_idx = CNT_W'(CNT_W - 1);
          end else begin
            w_shift = 1'b1;
          end
        end
        CNT: begin
          if (w_last) begin
            if (r_n != '0) begin
              w_load     = 1'b1;
              w_val      = r_data;
              w_last_idx = r_n - CNT_W'(1);
            end
          end else begin
            w_shift = 1'b1;
          end
        end
        DATA: begin
          if (!w_last) w_shift = 1'b1;
        end
        default: begin
          w_load  = 1'b0;
          w_shift = 1'b0;
        end
      endcase
    end
  end

  tx_field_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_val      (w_val),
    .i_last_idx (w_last_idx),
    .o_first    (w_first),
    .o_next     (w_next),
    .o_last     (w_last)
  );

  // The stop level, done pulse and return to IDLE share the edge that ends the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_port  <= '0;
      r_n     <= '0;
      r_data  <= '0;
      SerOut  <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
      remain  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_port  <= port_num;
            r_n     <= data_num;
            r_data  <= data;
            busy    <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (clk_en) begin
            SerOut  <= START_BIT;
            r_state <= START;
          end
        end
        START: begin
          if (clk_en) begin
            SerOut  <= w_first;
            r_state <= PORT;
          end
        end
        PORT: begin
          if (clk_en) begin
            if (w_last) begin
              SerOut  <= w_first;
              r_state <= CNT;
            end else begin
              SerOut <= w_next;
            end
          end
        end
        CNT: begin
          if (clk_en) begin
            if (!w_last) begin
              SerOut <= w_next;
            end else if (r_n != '0) begin
              SerOut  <= w_first;
              remain  <= {1'b0, r_n};
              r_state <= DATA;
            end else begin
              SerOut  <= IDLE_LEVEL;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (clk_en) begin
            if (w_last) begin
              SerOut  <= IDLE_LEVEL;
              remain  <= '0;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              SerOut <= w_next;
              remain <= remain - (CNT_W+1)'(1);
            end
          end
        end
        default: begin
          SerOut  <= IDLE_LEVEL;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// tb_serial_frame_tx : randomized frame checks against a bit-list model of the frame
// Rev 1.0
// ============================================================================
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [1:0]  port_num;
  logic [3:0]  data_num;
  logic [14:0] data;
  logic        SerOut;
  logic        busy;
  logic        done;
  logic [4:0]  remain;

  int total = 0;
  int bad   = 0;
  int en_period = 1;
  int en_cnt    = 0;

  serial_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .start    (start),
    .port_num (port_num),
    .data_num (data_num),
    .data     (data),
    .SerOut   (SerOut),
    .busy     (busy),
    .done     (done),
    .remain   (remain)
  );

  always #5 clk = ~clk;

  initial begin
    clk_en = 1'b0;
    forever begin
      @(negedge clk);
      en_cnt = en_cnt + 1;
      if (en_cnt >= en_period) en_cnt = 0;
      clk_en = (en_cnt == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  task automatic drive_req(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d);
    @(negedge clk);
    start    = 1'b1;
    port_num = p;
    data_num = n;
    data     = d;
  endtask

  // Expects the accept edge to be the next posedge, then follows the frame bit by bit.
  task automatic test_frame(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d,
                            input bit poke, input bit hold,
                            input logic [1:0] np, input logic [3:0] nn, input logic [14:0] nd);
    bit         exp_bits[$];
    int         k = 0;
    int         cyc = 0;
    int         budget;
    bit         en;
    bit         poked = 0;
    bit         poke_clr = 0;
    logic [4:0] exp_rem;

    exp_bits.push_back(1'b0);
    for (int i = 1; i >= 0; i--) exp_bits.push_back(p[i]);
    for (int i = 3; i >= 0; i--) exp_bits.push_back(n[i]);
    for (int i = 0; i < int'(n); i++) exp_bits.push_back(d[i]);
    budget = (exp_bits.size() + 3) * en_period + 10;

    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || SerOut !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL accept p=%0d n=%0d: busy=%b SerOut=%b done=%b, need busy=1 SerOut=1 done=0",
               p, n, busy, SerOut, done);
    end
    if (hold) begin
      port_num = np;
      data_num = nn;
      data     = nd;
    end else begin
      start    = 1'b0;
      port_num = 2'($urandom);
      data_num = 4'($urandom);
      data     = 15'($urandom);
    end

    while (k <= exp_bits.size() && cyc < budget) begin
      @(posedge clk);
      en = clk_en;
      #1;
      cyc++;
      if (en) begin
        if (k < exp_bits.size()) begin
          exp_rem = (k >= 7) ? 5'(int'(n) - (k - 7)) : 5'd0;
          total++;
          if (SerOut !== exp_bits[k] || busy !== 1'b1 || done !== 1'b0 || remain !== exp_rem) begin
            bad++;
            $display("FAIL bit%0d p=%0d n=%0d: SerOut=%b busy=%b done=%b remain=%0d, need SerOut=%b busy=1 done=0 remain=%0d",
                     k, p, n, SerOut, busy, done, remain, exp_bits[k], exp_rem);
          end
        end else begin
          total++;
          if (SerOut !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || remain !== 5'd0) begin
            bad++;
            $display("FAIL end p=%0d n=%0d: SerOut=%b done=%b busy=%b remain=%0d, need SerOut=1 done=1 busy=0 remain=0",
                     p, n, SerOut, done, busy, remain);
          end
        end
        k++;
      end else begin
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL early_done bit%0d p=%0d n=%0d: done=%b, need 0", k, p, n, done);
        end
      end
      if (poke && k == 3 && !poked) begin
        start    = 1'b1;
        port_num = 2'($urandom);
        data_num = 4'($urandom);
        data     = 15'($urandom);
        poked    = 1;
        poke_clr = 1;
      end else if (poke_clr) begin
        start    = 1'b0;
        poke_clr = 0;
      end
    end

    if (k <= exp_bits.size()) begin
      total++;
      bad++;
      $display("FAIL timeout p=%0d n=%0d: reached bit %0d of %0d, need frame end", p, n, k, exp_bits.size());
    end

    if (!hold) begin
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || SerOut !== 1'b1) begin
        bad++;
        $display("FAIL after_end p=%0d n=%0d: done=%b busy=%b SerOut=%b, need done=0 busy=0 SerOut=1",
                 p, n, done, busy, SerOut);
      end
    end
  endtask

  task automatic test_reset();
    bit clean = 1;
    #1;
    total++;
    if (SerOut !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || remain !== 5'd0) begin
      bad++;
      $display("FAIL reset_state: SerOut=%b busy=%b done=%b remain=%0d, need 1 0 0 0",
               SerOut, busy, done, remain);
    end
    @(negedge clk);
    rst = 1'b1;

    en_period = 1;
    drive_req(2'd3, 4'd8, 15'($urandom));
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || remain === 5'd0) begin
      bad++;
      $display("FAIL midframe: busy=%b remain=%0d, need busy=1 remain>0", busy, remain);
    end
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (SerOut !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || remain !== 5'd0) begin
      bad++;
      $display("FAIL async_abort: SerOut=%b busy=%b done=%b remain=%0d, need 1 0 0 0",
               SerOut, busy, done, remain);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || SerOut !== 1'b1 || busy !== 1'b0) clean = 0;
    end
    total++;
    if (!clean) begin
      bad++;
      $display("FAIL post_abort: activity after abort, need done=0 SerOut=1 busy=0 throughout");
    end
  endtask

  task automatic test_spec_example();
    en_period = 4;
    drive_req(2'd2, 4'd3, 15'b101);
    test_frame(2'd2, 4'd3, 15'b101, 0, 0, 2'd0, 4'd0, 15'd0);
  endtask

  task automatic test_header_only();
    logic [14:0] d = 15'($urandom);
    en_period = 3;
    drive_req(2'd1, 4'd0, d);
    test_frame(2'd1, 4'd0, d, 0, 0, 2'd0, 4'd0, 15'd0);
  endtask

  task automatic test_full_continuous();
    en_period = 1;
    drive_req(2'd3, 4'd15, 15'h5555);
    test_frame(2'd3, 4'd15, 15'h5555, 0, 0, 2'd0, 4'd0, 15'd0);
  endtask

  task automatic test_busy_ignore();
    logic [14:0] d = 15'($urandom);
    en_period = 2;
    drive_req(2'd0, 4'd6, d);
    test_frame(2'd0, 4'd6, d, 1, 0, 2'd0, 4'd0, 15'd0);
  endtask

  task automatic test_back_to_back();
    logic [14:0] da = 15'($urandom);
    logic [14:0] db = 15'($urandom);
    en_period = 4;
    drive_req(2'd1, 4'd2, da);
    test_frame(2'd1, 4'd2, da, 0, 1, 2'd2, 4'd4, db);
    test_frame(2'd2, 4'd4, db, 0, 0, 2'd0, 4'd0, 15'd0);
  endtask

  task automatic test_random();
    logic [1:0]  p;
    logic [3:0]  n;
    logic [14:0] d;
    for (int it = 0; it < 16; it++) begin
      p = 2'($urandom);
      n = 4'($urandom);
      d = 15'($urandom);
      en_period = int'($urandom_range(1, 4));
      drive_req(p, n, d);
      test_frame(p, n, d, bit'($urandom_range(0, 1)), 0, 2'd0, 4'd0, 15'd0);
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    port_num = '0;
    data_num = '0;
    data     = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_spec_example();
    test_header_only();
    test_full_continuous();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
